// File: rtl/lab4_branch_pht_sched.sv
// Branch PHT access scheduler: one SRAM port shared by predictions and a 2-deep update queue.
// Build option: define LAB4_BRANCH_PHT_UPD_PRIO_EN to give queued updates strict priority over predictions.
module lab4_branch_pht_sched #(
  parameter  int PHT_size = 2048,
  localparam int IW       = $clog2(PHT_size)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pred_req_val,
  output logic          pred_req_rdy,
  input  logic [IW-1:0] pred_req_idx,
  output logic          pred_resp_val,
  output logic          pred_resp_taken,
  input  logic          upd_req_val,
  output logic          upd_req_rdy,
  input  logic [IW-1:0] upd_req_idx,
  input  logic          upd_req_taken,
  output logic          pht_en,
  output logic          pht_wen,
  output logic [IW-1:0] pht_idx,
  output logic [1:0]    pht_wdata,
  input  logic [1:0]    pht_rdata,
  output logic          ghr_shift,
  output logic          ghr_shift_val
);

  typedef enum logic {S_IDLE, S_UPD_WRITE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [IW-1:0] ent0_idx_q, ent1_idx_q;
  logic          ent0_tkn_q, ent1_tkn_q;
  logic          resp_val_q;

  logic          pred_gate;
  logic          pred_hs;
  logic          upd_hs;
  logic          pop;
  logic [1:0]    cnt_after_pop;
  logic [1:0]    ctr_nxt;
  logic          ctr_sat;

`ifdef LAB4_BRANCH_PHT_UPD_PRIO_EN
  assign pred_gate = (cnt_q == 2'd0);
`else
  assign pred_gate = (cnt_q != 2'd2);
`endif

  // Ready outputs are gated by the raw reset so they read 0 while reset is held.
  assign pred_req_rdy  = reset & (state_q == S_IDLE) & pred_gate;
  assign upd_req_rdy   = reset & (cnt_q != 2'd2);
  assign pred_hs       = pred_req_val & pred_req_rdy;
  assign upd_hs        = upd_req_val & upd_req_rdy;
  assign ghr_shift     = upd_hs;
  assign ghr_shift_val = upd_hs & upd_req_taken;

  assign pred_resp_val   = resp_val_q;
  assign pred_resp_taken = resp_val_q & pht_rdata[1];

  always_comb begin
    state_d   = state_q;
    pht_en    = 1'b0;
    pht_wen   = 1'b0;
    pht_idx   = '0;
    pht_wdata = 2'd0;
    pop       = 1'b0;
    ctr_nxt   = 2'd0;
    ctr_sat   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pred_hs) begin
          pht_en  = 1'b1;
          pht_idx = pred_req_idx;
        end else if (cnt_q != 2'd0) begin
          pht_en  = 1'b1;
          pht_idx = ent0_idx_q;
          state_d = S_UPD_WRITE;
        end
      end
      S_UPD_WRITE: begin
        pop     = 1'b1;
        state_d = S_IDLE;
        if (ent0_tkn_q) begin
          ctr_sat = (pht_rdata == 2'd3);
          ctr_nxt = pht_rdata + 2'd1;
        end else begin
          ctr_sat = (pht_rdata == 2'd0);
          ctr_nxt = pht_rdata - 2'd1;
        end
        // A saturated counter would be rewritten unchanged, so the write is skipped.
        if (!ctr_sat) begin
          pht_en    = 1'b1;
          pht_wen   = 1'b1;
          pht_idx   = ent0_idx_q;
          pht_wdata = ctr_nxt;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cnt_after_pop = cnt_q - {1'b0, pop};
  assign cnt_d         = cnt_after_pop + {1'b0, upd_hs};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      ent0_idx_q <= '0;
      ent1_idx_q <= '0;
      ent0_tkn_q <= 1'b0;
      ent1_tkn_q <= 1'b0;
      resp_val_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      resp_val_q <= pred_hs;
      if (pop) begin
        ent0_idx_q <= ent1_idx_q;
        ent0_tkn_q <= ent1_tkn_q;
      end
      // Push lands after the pop shift, so a same-cycle push into slot 0 overrides it.
      if (upd_hs) begin
        if (cnt_after_pop == 2'd0) begin
          ent0_idx_q <= upd_req_idx;
          ent0_tkn_q <= upd_req_taken;
        end else begin
          ent1_idx_q <= upd_req_idx;
          ent1_tkn_q <= upd_req_taken;
        end
      end
    end
  end

endmodule

// File: tb/tb_lab4_branch_pht_sched.sv
// Directed bench for lab4_branch_pht_sched with a behavioural single-port PHT SRAM.
module tb_lab4_branch_pht_sched;

  localparam int PHT_SIZE = 2048;
  localparam int IW       = $clog2(PHT_SIZE);

  logic          clk = 1'b0;
  logic          reset;
  logic          pred_req_val, pred_req_rdy;
  logic [IW-1:0] pred_req_idx;
  logic          pred_resp_val, pred_resp_taken;
  logic          upd_req_val, upd_req_rdy;
  logic [IW-1:0] upd_req_idx;
  logic          upd_req_taken;
  logic          pht_en, pht_wen;
  logic [IW-1:0] pht_idx;
  logic [1:0]    pht_wdata;
  logic [1:0]    pht_rdata;
  logic          ghr_shift, ghr_shift_val;

  logic [1:0]    mem [PHT_SIZE];
  logic          pl_en;
  logic [IW-1:0] pl_idx;
  logic [1:0]    pl_val;
  int            wr_cnt = 0;
  int            wr_base;
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  lab4_branch_pht_sched #(.PHT_size(PHT_SIZE)) dut (
    .clk(clk), .reset(reset),
    .pred_req_val(pred_req_val), .pred_req_rdy(pred_req_rdy), .pred_req_idx(pred_req_idx),
    .pred_resp_val(pred_resp_val), .pred_resp_taken(pred_resp_taken),
    .upd_req_val(upd_req_val), .upd_req_rdy(upd_req_rdy), .upd_req_idx(upd_req_idx),
    .upd_req_taken(upd_req_taken),
    .pht_en(pht_en), .pht_wen(pht_wen), .pht_idx(pht_idx), .pht_wdata(pht_wdata),
    .pht_rdata(pht_rdata),
    .ghr_shift(ghr_shift), .ghr_shift_val(ghr_shift_val)
  );

  // SRAM model: read data registered one cycle after a read command; preload port for setup.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_val;
    end else if (pht_en) begin
      if (pht_wen) begin
        mem[pht_idx] <= pht_wdata;
        wr_cnt       <= wr_cnt + 1;
      end else begin
        pht_rdata <= mem[pht_idx];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nc();
    @(posedge clk);
    #2;
  endtask

  int pl_i [10] = '{1, 3, 4, 5, 7, 8, 9, 10, 12, 13};
  int pl_v [10] = '{3, 3, 0, 2, 1, 1, 2, 0, 1, 1};

  initial begin
    reset         = 1'b0;
    pred_req_val  = 1'b1;
    pred_req_idx  = '0;
    upd_req_val   = 1'b1;
    upd_req_idx   = '0;
    upd_req_taken = 1'b1;
    pl_en         = 1'b0;
    pl_idx        = '0;
    pl_val        = 2'd0;
    pht_rdata     = 2'd0;

    // Preload while reset holds the DUT off the port.
    for (int i = 0; i < 10; i++) begin
      pl_en  = 1'b1;
      pl_idx = IW'(pl_i[i]);
      pl_val = 2'(pl_v[i]);
      nc();
    end
    pl_en = 1'b0;
    #1;
    chk("rst_pht_en", pht_en, 0);
    chk("rst_pht_wen", pht_wen, 0);
    chk("rst_resp_val", pred_resp_val, 0);
    chk("rst_ghr_shift", ghr_shift, 0);
    chk("rst_ghr_val", ghr_shift_val, 0);
    chk("rst_pred_rdy", pred_req_rdy, 0);
    chk("rst_upd_rdy", upd_req_rdy, 0);
    pred_req_val = 1'b0;
    upd_req_val  = 1'b0;
    reset        = 1'b1;
    #1;
    chk("rel_pred_rdy", pred_req_rdy, 1);
    chk("rel_upd_rdy", upd_req_rdy, 1);

    // Idle predict, PHT[5]=2
    nc(); pred_req_val = 1'b1; pred_req_idx = 5; #1;
    chk("p5_rdy", pred_req_rdy, 1);
    chk("p5_en", pht_en, 1);
    chk("p5_wen", pht_wen, 0);
    chk("p5_idx", pht_idx, 5);
    nc(); pred_req_val = 1'b0; #1;
    chk("p5_resp_val", pred_resp_val, 1);
    chk("p5_resp_taken", pred_resp_taken, 1);
    nc(); #1;
    chk("p5_resp_done", pred_resp_val, 0);

    // Update increment, PHT[7]=1 taken -> 2
    nc(); upd_req_val = 1'b1; upd_req_idx = 7; upd_req_taken = 1'b1; #1;
    chk("u7_rdy", upd_req_rdy, 1);
    chk("u7_ghr", ghr_shift, 1);
    chk("u7_ghr_val", ghr_shift_val, 1);
    chk("u7_no_cmd", pht_en, 0);
    nc(); upd_req_val = 1'b0; #1;
    chk("u7_rd_en", pht_en, 1);
    chk("u7_rd_wen", pht_wen, 0);
    chk("u7_rd_idx", pht_idx, 7);
    nc(); #1;
    chk("u7_wr_en", pht_en, 1);
    chk("u7_wr_wen", pht_wen, 1);
    chk("u7_wr_idx", pht_idx, 7);
    chk("u7_wdata", pht_wdata, 2);
    nc(); #1;
    chk("u7_idle", pht_en, 0);
    chk("u7_mem", mem[7], 2);
    chk("u7_rdy_after", upd_req_rdy, 1);

    // Saturation: PHT[3]=3 taken, PHT[4]=0 not taken
    nc(); upd_req_val = 1'b1; upd_req_idx = 3; upd_req_taken = 1'b1; #1;
    chk("s3_ghr_val", ghr_shift_val, 1);
    nc(); upd_req_idx = 4; upd_req_taken = 1'b0; #1;
    chk("s4_rdy", upd_req_rdy, 1);
    chk("s4_ghr", ghr_shift, 1);
    chk("s4_ghr_val", ghr_shift_val, 0);
    chk("s3_rd_en", pht_en, 1);
    chk("s3_rd_wen", pht_wen, 0);
    chk("s3_rd_idx", pht_idx, 3);
    nc(); upd_req_val = 1'b0; #1;
    chk("s_full_rdy", upd_req_rdy, 0);
    chk("s3_sat_en", pht_en, 0);
    chk("s3_sat_idx", pht_idx, 0);
    chk("s3_sat_wdata", pht_wdata, 0);
    nc(); #1;
    chk("s4_rd_en", pht_en, 1);
    chk("s4_rd_wen", pht_wen, 0);
    chk("s4_rd_idx", pht_idx, 4);
    nc(); #1;
    chk("s4_sat_en", pht_en, 0);
    chk("s4_sat_wdata", pht_wdata, 0);
    nc(); #1;
    chk("s3_mem", mem[3], 3);
    chk("s4_mem", mem[4], 0);
    chk("s_idle", pht_en, 0);

`ifndef LAB4_BRANCH_PHT_UPD_PRIO_EN
    // Prediction priority: continuous preds on idx 1, three updates (8 T, 9 T, 10 NT)
    nc(); pred_req_val = 1'b1; pred_req_idx = 1;
    upd_req_val = 1'b1; upd_req_idx = 8; upd_req_taken = 1'b1; #1;
    chk("q0_pred_rdy", pred_req_rdy, 1);
    chk("q0_idx", pht_idx, 1);
    chk("q0_upd_rdy", upd_req_rdy, 1);
    nc(); upd_req_idx = 9; #1;
    chk("q1_pred_rdy", pred_req_rdy, 1);
    chk("q1_resp_val", pred_resp_val, 1);
    chk("q1_resp_taken", pred_resp_taken, 1);
    chk("q1_ghr", ghr_shift, 1);
    nc(); upd_req_idx = 10; upd_req_taken = 1'b0; #1;
    chk("q2_upd_stall", upd_req_rdy, 0);
    chk("q2_pred_stall", pred_req_rdy, 0);
    chk("q2_ghr", ghr_shift, 0);
    chk("q2_drain_idx", pht_idx, 8);
    chk("q2_drain_wen", pht_wen, 0);
    chk("q2_resp_val", pred_resp_val, 1);
    nc(); #1;
    chk("q3_pred_rdy", pred_req_rdy, 0);
    chk("q3_wen", pht_wen, 1);
    chk("q3_idx", pht_idx, 8);
    chk("q3_wdata", pht_wdata, 2);
    chk("q3_resp_val", pred_resp_val, 0);
    nc(); #1;
    chk("q4_pred_rdy", pred_req_rdy, 1);
    chk("q4_idx", pht_idx, 1);
    chk("q4_upd_rdy", upd_req_rdy, 1);
    chk("q4_ghr", ghr_shift, 1);
    chk("q4_ghr_val", ghr_shift_val, 0);
    nc(); upd_req_val = 1'b0; #1;
    chk("q5_pred_rdy", pred_req_rdy, 0);
    chk("q5_idx", pht_idx, 9);
    chk("q5_resp_val", pred_resp_val, 1);
    nc(); #1;
    chk("q6_wen", pht_wen, 1);
    chk("q6_idx", pht_idx, 9);
    chk("q6_wdata", pht_wdata, 3);
    nc(); #1;
    chk("q7_pred_rdy", pred_req_rdy, 1);
    chk("q7_idx", pht_idx, 1);
    nc(); pred_req_val = 1'b0; #1;
    chk("q8_en", pht_en, 1);
    chk("q8_wen", pht_wen, 0);
    chk("q8_idx", pht_idx, 10);
    chk("q8_resp_val", pred_resp_val, 1);
    nc(); #1;
    chk("q9_sat_en", pht_en, 0);
    nc(); #1;
    chk("q_mem8", mem[8], 2);
    chk("q_mem9", mem[9], 3);
    chk("q_mem10", mem[10], 0);
    chk("q_upd_rdy", upd_req_rdy, 1);
`else
    // Update priority: pred stalls until the queue drains
    nc(); pred_req_val = 1'b1; pred_req_idx = 1;
    upd_req_val = 1'b1; upd_req_idx = 8; upd_req_taken = 1'b1; #1;
    chk("h0_pred_rdy", pred_req_rdy, 1);
    chk("h0_idx", pht_idx, 1);
    chk("h0_ghr", ghr_shift, 1);
    nc(); upd_req_val = 1'b0; #1;
    chk("h1_pred_rdy", pred_req_rdy, 0);
    chk("h1_idx", pht_idx, 8);
    chk("h1_wen", pht_wen, 0);
    nc(); #1;
    chk("h2_pred_rdy", pred_req_rdy, 0);
    chk("h2_wen", pht_wen, 1);
    chk("h2_wdata", pht_wdata, 2);
    nc(); #1;
    chk("h3_pred_rdy", pred_req_rdy, 1);
    chk("h3_idx", pht_idx, 1);
    nc(); pred_req_val = 1'b0; #1;
`endif

    // Reset during UPD_WRITE with two updates queued (12 T, 13 T)
    nc(); upd_req_val = 1'b1; upd_req_idx = 12; upd_req_taken = 1'b1; #1;
    chk("r0_ghr", ghr_shift, 1);
    nc(); upd_req_idx = 13; #1;
    chk("r1_idx", pht_idx, 12);
    chk("r1_wen", pht_wen, 0);
    nc(); upd_req_val = 1'b0; #1;
    chk("r2_wen", pht_wen, 1);
    chk("r2_idx", pht_idx, 12);
    wr_base = wr_cnt;
    reset = 1'b0;
    #1;
    chk("r2_rst_en", pht_en, 0);
    chk("r2_rst_upd_rdy", upd_req_rdy, 0);
    nc(); #1;
    reset = 1'b1;
    #1;
    chk("r_rel_upd_rdy", upd_req_rdy, 1);
    chk("r_rel_pred_rdy", pred_req_rdy, 1);
    repeat (4) nc();
    #1;
    chk("r_no_writes", wr_cnt, wr_base);
    chk("r_mem12", mem[12], 1);
    chk("r_mem13", mem[13], 1);
    chk("r_idle_en", pht_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lab4_branch_pht_sched.md
LAB4_BRANCH_PHT_SCHED -- requirements
Module: lab4_branch_pht_sched

Interface
REQ-001 Parameter PHT_size, default 2048, SHALL set the number of 2-bit PHT entries; a power of two; IW = $clog2(PHT_size).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; asserted (0) SHALL force reset state immediately, independent of clk.
REQ-004 pred_req_val / pred_req_rdy / pred_req_idx  in/out/in  1/1/IW  prediction lookup request; val/rdy handshake.
REQ-005 pred_resp_val / pred_resp_taken  out/out  1/1  prediction response; no backpressure.
REQ-006 upd_req_val / upd_req_rdy / upd_req_idx / upd_req_taken  in/out/in/in  1/1/IW/1  resolved-branch update request; val/rdy handshake.
REQ-007 pht_en / pht_wen / pht_idx / pht_wdata  out/out/out/out  1/1/IW/2  single-port PHT SRAM command.
REQ-008 pht_rdata  in  2  SRAM read data, valid exactly one cycle after a read command (pht_en=1, pht_wen=0).
REQ-009 ghr_shift / ghr_shift_val  out/out  1/1  one-cycle pulse shifting the GHR, with the shifted-in outcome.

Function
REQ-010 A 2-entry FIFO SHALL buffer accepted updates (idx, taken); upd_req_rdy SHALL be 1 iff the registered FIFO count < 2; no enqueue when full, even if a pop occurs in the same cycle.
REQ-011 On an update handshake, ghr_shift SHALL be 1 in that same cycle, with ghr_shift_val = upd_req_taken.
REQ-012 FSM states: IDLE and UPD_WRITE; the SRAM port SHALL carry at most one command per cycle.
REQ-013 pred_req_rdy SHALL be 1 only in IDLE, gated by the priority rule of REQ-024.
REQ-014 IDLE with pred handshake: pht_en=1, pht_wen=0, pht_idx=pred_req_idx; state stays IDLE.
REQ-015 IDLE, no pred handshake, FIFO non-empty: pht_en=1, pht_wen=0, pht_idx=head idx; next state UPD_WRITE.
REQ-016 UPD_WRITE: next counter = pht_rdata+1 if head taken, pht_rdata-1 if not taken, saturating at 3 and 0.
REQ-017 UPD_WRITE: pht_en=1, pht_wen=1, pht_idx=head idx, pht_wdata=next counter, unless the counter is already saturated in the update direction (3 taken, 0 not taken), in which case pht_en=0.
REQ-018 UPD_WRITE SHALL pop the FIFO head and return to IDLE unconditionally; each update occupies exactly 2 port cycles.
REQ-019 pred_resp_val SHALL be 1 exactly one cycle after each pred handshake, with pred_resp_taken = pht_rdata[1].
REQ-020 A prediction read for an index with a pending queued update SHALL return the pre-update value; no forwarding.
REQ-021 Simultaneous pred and update handshakes in IDLE SHALL both be accepted: the prediction uses the port and the update is enqueued.
REQ-022 pht_idx/pht_wdata SHALL be 0 whenever pht_en=0.

Reset
REQ-023 While reset=0: state=IDLE, FIFO empty, and pht_en, pht_wen, pred_resp_val, ghr_shift, ghr_shift_val, pred_req_rdy, upd_req_rdy are all 0. After release, upd_req_rdy=1 and pred_req_rdy=1. Reset mid-update SHALL discard queued and in-flight updates with no write issued. PHT contents are not reset.

Configuration
REQ-024 Macro LAB4_BRANCH_PHT_UPD_PRIO_EN.
- Defined: updates have strict priority; pred_req_rdy = IDLE && FIFO empty.
- Undefined: predictions have priority; pred_req_rdy = IDLE && FIFO count < 2, so a full FIFO forces a drain.

Verification
REQ-025 Idle predict: pred idx=5, PHT[5]=2 -> read idx 5 in the same cycle; next cycle pred_resp_val=1, taken=1.
REQ-026 Update increment: upd idx=7 taken, PHT[7]=1, no preds -> ghr_shift=1, val=1; read 7, then write 7 with wdata=2; FIFO empty after 2 cycles.
REQ-027 Saturation: upd idx=3 taken with PHT[3]=3, and upd idx=4 not-taken with PHT[4]=0 -> each performs a read, then a UPD_WRITE cycle with pht_en=0.
REQ-028 Priority (macro undefined): continuous preds plus 3 updates -> third update stalls (upd_req_rdy=0); pred_req_rdy drops when FIFO=2; drain occurs; preds resume.
REQ-029 Priority (macro defined): pred and update pending together -> pred_req_rdy=0 until FIFO empty, then pred accepted.
REQ-030 Reset mid-op: assert reset during UPD_WRITE with 2 queued updates -> pht_en=0 immediately; no writes after release; upd_req_rdy=1.
